// File: rtl/control_sequencer.sv
// Instruction control sequencer: fetch/decode/execute FSM driven by an
// external timing count, producing one-hot timing and control strobes.
module control_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  sc,
  input  logic [15:0] mem_data,
  output logic [7:0]  t,
  output logic        ar_ld_pc,
  output logic        mem_rd,
  output logic        ir_ld,
  output logic        pc_inc,
  output logic        ar_ld_ir,
  output logic        ar_ld_mem,
  output logic        exec_en,
  output logic        sc_clr,
  output logic [15:0] ir,
  output logic [7:0]  d,
  output logic        i_flag,
  output logic        halted,
  output logic        sync_err
);

  typedef enum logic [1:0] {
    FETCH,
    DECODE,
    EXEC,
    HALT
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_ir;
  logic [7:0]  r_d;
  logic        r_i_flag;
  logic        r_sync_err;
  logic [2:0]  w_end;
  logic        w_desync;
  logic        w_hlt;

  assign ir       = r_ir;
  assign d        = r_d;
  assign i_flag   = r_i_flag;
  assign sync_err = r_sync_err;
  assign halted   = (r_state == HALT);
  assign w_hlt    = r_d[7] & r_ir[0] & (sc == 3'd3);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= FETCH;
      r_ir       <= 16'h0000;
      r_d        <= 8'h00;
      r_i_flag   <= 1'b0;
      r_sync_err <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_sync_err <= w_desync;
      if (ir_ld)
        r_ir <= mem_data;
      if (ar_ld_ir) begin
        r_d      <= 8'd1 << r_ir[14:12];
        r_i_flag <= r_ir[15];
      end
    end
  end

  // Last execute cycle of a memory-reference instruction
  always_comb begin
    w_end = 3'd5;
    unique case (1'b1)
      (r_d[3] | r_d[4]): w_end = 3'd4;
      r_d[6]:            w_end = 3'd6;
      default:           w_end = 3'd5;
    endcase
  end

  always_comb begin
    t         = 8'h00;
    ar_ld_pc  = 1'b0;
    mem_rd    = 1'b0;
    ir_ld     = 1'b0;
    pc_inc    = 1'b0;
    ar_ld_ir  = 1'b0;
    ar_ld_mem = 1'b0;
    exec_en   = 1'b0;
    sc_clr    = 1'b0;
    w_desync  = 1'b0;
    w_next    = r_state;
    if (!reset) begin
      if (r_state != HALT)
        t = 8'd1 << sc;
      unique case (r_state)
        FETCH: begin
          if (sc == 3'd0) begin
            ar_ld_pc = 1'b1;
          end else if (sc == 3'd1) begin
            mem_rd = 1'b1;
            ir_ld  = 1'b1;
            pc_inc = 1'b1;
            w_next = DECODE;
          end
        end
        DECODE: begin
          if (sc == 3'd0) begin
            w_desync = 1'b1;
            w_next   = FETCH;
          end else if (sc == 3'd2) begin
            ar_ld_ir = 1'b1;
            w_next   = EXEC;
          end
        end
        EXEC: begin
          if (sc == 3'd0) begin
            w_desync = 1'b1;
            w_next   = FETCH;
          end else if (sc == 3'd3) begin
            if (r_d[7]) begin
              exec_en = 1'b1;
              sc_clr  = 1'b1;
            end else if (r_i_flag) begin
              mem_rd    = 1'b1;
              ar_ld_mem = 1'b1;
            end
          end else if (!r_d[7] && sc >= 3'd4 && sc <= w_end) begin
            exec_en = 1'b1;
            sc_clr  = (sc == w_end);
          end
          // Count ran off the end without finishing: resynchronise
          if (sc == 3'd7 && !sc_clr) begin
            sc_clr   = 1'b1;
            w_desync = 1'b1;
          end
          if (sc_clr)
            w_next = w_hlt ? HALT : FETCH;
        end
        HALT: begin
          w_next = HALT;
        end
        default: w_next = FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: instruction-level timeline
// model with random instruction words plus directed corner cases.
module tb_control_sequencer;

  logic        clk;
  logic        reset;
  logic [2:0]  sc;
  logic [15:0] mem_data;
  logic [7:0]  t;
  logic        ar_ld_pc, mem_rd, ir_ld, pc_inc;
  logic        ar_ld_ir, ar_ld_mem, exec_en, sc_clr;
  logic [15:0] ir;
  logic [7:0]  d;
  logic        i_flag, halted, sync_err;

  int total = 0;
  int bad   = 0;

  control_sequencer dut (
    .clk(clk), .reset(reset), .sc(sc), .mem_data(mem_data),
    .t(t), .ar_ld_pc(ar_ld_pc), .mem_rd(mem_rd), .ir_ld(ir_ld),
    .pc_inc(pc_inc), .ar_ld_ir(ar_ld_ir), .ar_ld_mem(ar_ld_mem),
    .exec_en(exec_en), .sc_clr(sc_clr), .ir(ir), .d(d),
    .i_flag(i_flag), .halted(halted), .sync_err(sync_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {ar_ld_pc, mem_rd, ir_ld, pc_inc, ar_ld_ir, ar_ld_mem, exec_en, sc_clr}
  function automatic logic [7:0] strb();
    return {ar_ld_pc, mem_rd, ir_ld, pc_inc,
            ar_ld_ir, ar_ld_mem, exec_en, sc_clr};
  endfunction

  // Final T-step of an instruction, from its opcode
  function automatic int end_t(input logic [15:0] w);
    case (w[14:12])
      3'd3, 3'd4: return 4;
      3'd6:       return 6;
      3'd7:       return 3;
      default:    return 5;
    endcase
  endfunction

  // Expected strobes of instruction w at timing step k
  function automatic logic [7:0] exp_strb(input logic [15:0] w, input int k);
    logic reg_io;
    reg_io = (w[14:12] == 3'd7);
    case (k)
      0: return 8'b1000_0000;
      1: return 8'b0111_0000;
      2: return 8'b0000_1000;
      3: begin
        if (reg_io)     return 8'b0000_0011;
        else if (w[15]) return 8'b0100_0100;
        else            return 8'b0000_0000;
      end
      default: begin
        if (!reg_io && k <= end_t(w))
          return {6'b0, 1'b1, (k == end_t(w))};
        return 8'h00;
      end
    endcase
  endfunction

  task automatic step(input int v, input logic [15:0] md);
    @(negedge clk);
    sc       = 3'(v);
    mem_data = md;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    sc    = 3'($urandom_range(0, 7));
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      sc = 3'(i);
      mem_data = 16'($urandom);
      #1;
      total++;
      if (strb() !== 8'h00 || t !== 8'h00) begin
        bad++;
        $display("FAIL reset_strobes sc=%0d strb=%h t=%h want 00/00",
                 i, strb(), t);
      end
      @(negedge clk);
    end
    reset = 1'b0;
    step(0, 16'h0);
    total++;
    if (ir !== 16'h0 || d !== 8'h0 || i_flag !== 1'b0 ||
        halted !== 1'b0 || sync_err !== 1'b0) begin
      bad++;
      $display("FAIL reset_regs ir=%h d=%h i=%b h=%b se=%b want 0",
               ir, d, i_flag, halted, sync_err);
    end
    total++;
    if (strb() !== 8'h80 || t !== 8'h01) begin
      bad++;
      $display("FAIL reset_t0 strb=%h t=%h want 80/01", strb(), t);
    end
  endtask

  // Runs one full non-halting instruction from T0 to its end cycle
  task automatic test_instr(input logic [15:0] w);
    logic [7:0] e;
    for (int k = 0; k <= end_t(w); k++) begin
      step(k, (k == 1) ? w : 16'($urandom));
      e = exp_strb(w, k);
      total++;
      if (strb() !== e || t !== (8'd1 << k)) begin
        bad++;
        $display("FAIL instr_%h_T%0d strb=%h t=%h want %h/%h",
                 w, k, strb(), t, e, 8'd1 << k);
      end
      if (k == 2) begin
        total++;
        if (ir !== w) begin
          bad++;
          $display("FAIL ir_capture got=%h want=%h", ir, w);
        end
      end
      if (k == 3) begin
        total++;
        if (d !== (8'd1 << w[14:12]) || i_flag !== w[15]) begin
          bad++;
          $display("FAIL decode_%h d=%h i=%b want %h/%b",
                   w, d, i_flag, 8'd1 << w[14:12], w[15]);
        end
      end
      total++;
      if (sync_err !== 1'b0 || halted !== 1'b0) begin
        bad++;
        $display("FAIL flags_%h_T%0d se=%b h=%b want 0/0",
                 w, k, sync_err, halted);
      end
    end
  endtask

  task automatic test_directed();
    test_instr(16'h2005);
    test_instr(16'hA005);
    test_instr(16'h3010);
    test_instr(16'h6010);
    test_instr(16'h7002);
  endtask

  task automatic test_random();
    logic [15:0] w;
    for (int n = 0; n < 40; n++) begin
      w = 16'($urandom);
      if (w[14:12] == 3'd7)
        w[0] = 1'b0;
      test_instr(w);
    end
  endtask

  task automatic test_back_to_back();
    test_instr(16'h4123);
    test_instr(16'h0fff);
    test_instr(16'hD456);
    step(0, 16'h0);
    total++;
    if (strb() !== 8'h80) begin
      bad++;
      $display("FAIL b2b_fetch strb=%h want 80", strb());
    end
  endtask

  task automatic test_halt();
    for (int k = 0; k < 4; k++) begin
      step(k, (k == 1) ? 16'h7001 : 16'($urandom));
      total++;
      if (strb() !== exp_strb(16'h7001, k)) begin
        bad++;
        $display("FAIL hlt_T%0d strb=%h want %h",
                 k, strb(), exp_strb(16'h7001, k));
      end
    end
    for (int s = 0; s < 8; s++) begin
      step(s, 16'($urandom));
      total++;
      if (halted !== 1'b1 || t !== 8'h00 || strb() !== 8'h00 ||
          ir !== 16'h7001 || d !== 8'h80) begin
        bad++;
        $display("FAIL halted_sc%0d h=%b t=%h strb=%h ir=%h d=%h want 1/00/00/7001/80",
                 s, halted, t, strb(), ir, d);
      end
    end
    do_reset();
    step(0, 16'h0);
    total++;
    if (halted !== 1'b0 || strb() !== 8'h80) begin
      bad++;
      $display("FAIL halt_exit h=%b strb=%h want 0/80", halted, strb());
    end
  endtask

  task automatic test_reset_mid_exec();
    for (int k = 0; k < 4; k++)
      step(k, (k == 1) ? 16'h2005 : 16'h0);
    @(negedge clk);
    sc    = 3'd4;
    reset = 1'b1;
    #1;
    total++;
    if (strb() !== 8'h00 || t !== 8'h00) begin
      bad++;
      $display("FAIL midreset_strb strb=%h t=%h want 00/00", strb(), t);
    end
    @(negedge clk);
    reset = 1'b0;
    sc    = 3'd0;
    #1;
    total++;
    if (ir !== 16'h0 || d !== 8'h0 || i_flag !== 1'b0 ||
        strb() !== 8'h80) begin
      bad++;
      $display("FAIL midreset_after ir=%h d=%h i=%b strb=%h want 0/0/0/80",
               ir, d, i_flag, strb());
    end
  endtask

  task automatic test_desync();
    step(0, 16'h0);
    step(1, 16'h2005);
    step(2, 16'h0);
    step(0, 16'h0);
    total++;
    if (strb() !== 8'h00) begin
      bad++;
      $display("FAIL desync0_strb strb=%h want 00", strb());
    end
    step(0, 16'h0);
    total++;
    if (sync_err !== 1'b1 || strb() !== 8'h80) begin
      bad++;
      $display("FAIL desync0_pulse se=%b strb=%h want 1/80", sync_err, strb());
    end
    step(0, 16'h0);
    total++;
    if (sync_err !== 1'b0) begin
      bad++;
      $display("FAIL desync0_width se=%b want 0", sync_err);
    end
    for (int k = 0; k < 5; k++)
      step(k, (k == 1) ? 16'h2005 : 16'h0);
    step(7, 16'h0);
    total++;
    if (strb() !== 8'h01 || t !== 8'h80) begin
      bad++;
      $display("FAIL desync7_clr strb=%h t=%h want 01/80", strb(), t);
    end
    step(0, 16'h0);
    total++;
    if (sync_err !== 1'b1 || strb() !== 8'h80) begin
      bad++;
      $display("FAIL desync7_pulse se=%b strb=%h want 1/80", sync_err, strb());
    end
    step(0, 16'h0);
    total++;
    if (sync_err !== 1'b0) begin
      bad++;
      $display("FAIL desync7_width se=%b want 0", sync_err);
    end
  endtask

  initial begin
    reset    = 1'b1;
    sc       = 3'd0;
    mem_data = 16'h0;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_desync();
    test_reset_mid_exec();
    test_halt();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 The block SHALL have no parameters; data width is fixed at 16 bits, address field at 12 bits and timing count at 3 bits.
REQ-002 clk  input  1  sole clock; all state SHALL update on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 sc  input  3  timing count from sequence_counter.
REQ-005 mem_data  input  16  instruction/operand word from memory; valid whenever mem_rd is high.
REQ-006 t  output  8  one-hot decode of sc, t[sc]=1.
REQ-007 ar_ld_pc, mem_rd, ir_ld, pc_inc, ar_ld_ir, ar_ld_mem, exec_en, sc_clr  outputs  1 each  control strobes.
REQ-008 ir  output  16  instruction register.
REQ-009 d  output  8  registered one-hot opcode decode of ir[14:12].
REQ-010 i_flag  output  1  registered indirect bit, ir[15].
REQ-011 halted  output  1  high while in HALT.
REQ-012 sync_err  output  1  one-cycle error pulse.

Function
REQ-013 FSM states SHALL be FETCH, DECODE, EXEC and HALT.
REQ-014 FSM transitions on the clock edge:
- FETCH->DECODE when sc==1.
- DECODE->EXEC when sc==2.
- EXEC->FETCH when sc_clr==1.
- HALT SHALL be exited only by reset.
REQ-015 t SHALL be combinational from sc and SHALL be 8'h00 in HALT or while reset is high.
REQ-016 In FETCH with sc==0, ar_ld_pc SHALL be 1.
REQ-017 In FETCH with sc==1:
- mem_rd, ir_ld and pc_inc SHALL be 1.
- ir SHALL capture mem_data on that edge.
REQ-018 In DECODE with sc==2:
- ar_ld_ir SHALL be 1.
- d SHALL load the one-hot of ir[14:12] and i_flag SHALL load ir[15] on that edge; both are valid from T3.
REQ-019 EXEC with d[7]=1 (register/IO), at sc==3:
- exec_en=1 and sc_clr=1.
- If additionally ir[0]==1 (HLT), the next state SHALL be HALT instead of FETCH.
REQ-020 EXEC with d[7]=0, i_flag=1, at sc==3: mem_rd=1 and ar_ld_mem=1.
REQ-021 EXEC with d[7]=0, i_flag=0, at sc==3: all strobes SHALL be 0.
REQ-022 Memory-reference execution, d[7]=0, for sc from 4 through the end cycle:
- exec_en SHALL be 1 on each of these cycles.
- sc_clr SHALL be 1 on the end cycle.
- End cycle: T5 for d[0], d[1], d[2] and d[5]; T4 for d[3] and d[4]; T6 for d[6].
REQ-023 Each strobe SHALL be combinational from state, sc, d and i_flag, with zero latency in the same cycle.
REQ-024 Strobes SHALL be 0 in any state/sc combination not listed above.
REQ-025 Desynchronisation:
- If sc==0 is seen in DECODE or EXEC, the FSM SHALL go to FETCH and sync_err SHALL pulse high for the next cycle.
- If sc==7 is seen in EXEC with no end cycle reached, sc_clr SHALL be forced to 1 and sync_err SHALL pulse.
REQ-026 In HALT, all strobes SHALL be 0; ir, d and i_flag SHALL hold their values.

Reset
REQ-027 On the edge with reset=1, the block SHALL set:
- state=FETCH
- ir=16'h0000, d=8'h00, i_flag=0
- halted=0, sync_err=0
REQ-028 While reset=1, all combinational strobes and t SHALL be forced to 0, regardless of sc.
REQ-029 Reset asserted mid-EXEC or in HALT SHALL have the same effect as reset from idle, with no partial completion.

Verification
REQ-030 LDA direct: mem_data=16'h2005, sc stepped 0..5 -> responses:
- T0: ar_ld_pc=1.
- T1: mem_rd=1, ir_ld=1, pc_inc=1; after the edge ir=16'h2005.
- T2: ar_ld_ir=1; after the edge d=8'h04, i_flag=0.
- T4, T5: exec_en=1.
- T5: sc_clr=1; state returns to FETCH.
REQ-031 LDA indirect: mem_data=16'hA005 -> i_flag=1; at T3 mem_rd=1 and ar_ld_mem=1; sc_clr=1 at T5.
REQ-032 STA: mem_data=16'h3010 -> sc_clr=1 at T4. ISZ: mem_data=16'h6010 -> sc_clr=1 at T6 and 0 at T4 and T5.
REQ-033 HLT: mem_data=16'h7001 -> at T3 exec_en=1 and sc_clr=1; halted=1 from the next cycle; t=8'h00 and all strobes 0 for sc=0..7 thereafter.
REQ-034 Reset while sc=4 in EXEC of LDA -> strobes 0 during reset; next cycle ir=16'h0000, d=8'h00, state FETCH; sc=0 then gives ar_ld_pc=1.
REQ-035 Desync: sc forced from 2 directly to 0 in EXEC -> sync_err=1 for exactly one cycle; state FETCH.
